// File: rtl/ext_mem_loader_pkg.sv
// Shared types and constants for the external data-memory image loader.
package ext_mem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic        MEMREQ_READ  = 1'b0;
    localparam logic        MEMREQ_WRITE = 1'b1;
    localparam int unsigned WORD_STRIDE  = 4;
    localparam int unsigned DATA_W       = 32;

endpackage

// File: rtl/ext_mem_loader_if.sv
// Stream input and external data-memory port of the loader.
//   master : loader side (drives in_rdy and the ext_dmemreq_* request)
//   slave  : stream source / memory side
interface ext_mem_loader_if;
    import ext_mem_loader_pkg::*;

    logic              in_val;
    logic              in_rdy;
    logic [DATA_W-1:0] in_data;
    logic              ext_dmemreq_val;
    logic              ext_dmemreq_type;
    logic [31:0]       ext_dmemreq_addr;
    logic [DATA_W-1:0] ext_dmemreq_wdata;
    logic [DATA_W-1:0] ext_dmemresp_rdata;

    modport master (
        input  in_val, in_data, ext_dmemresp_rdata,
        output in_rdy, ext_dmemreq_val, ext_dmemreq_type,
               ext_dmemreq_addr, ext_dmemreq_wdata
    );

    modport slave (
        output in_val, in_data, ext_dmemresp_rdata,
        input  in_rdy, ext_dmemreq_val, ext_dmemreq_type,
               ext_dmemreq_addr, ext_dmemreq_wdata
    );
endinterface

// File: rtl/ext_mem_loader_acc.sv
// Wrapping 32-bit accumulator with synchronous clear and add-enable.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : zero the accumulator (wins over en_i)
//   en_i     : add d_i on this edge
//   q_o      : registered sum
module ext_mem_loader_acc
    import ext_mem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst)        acc_q <= '0;
        else if (clr_i) acc_q <= '0;
        else if (en_i)  acc_q <= acc_q + d_i;
    end

    assign q_o = acc_q;

endmodule

// File: rtl/ext_mem_loader.sv
// Loads a stream of 32-bit words into consecutive external data-memory words
// starting at BASE_ADDR while holding the core in reset.
// Optional readback checksum verify: define EXT_MEM_LOADER_VERIFY_EN.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a load (sampled only in IDLE), num_words latched then
//   mem        : stream in (val/rdy/data) and memory request/response port
//   proc_rst   : core reset = rst | busy
//   busy       : WRITE or VERIFY in progress
//   done       : one-cycle completion pulse
//   err        : sticky error (oversize request, or readback mismatch)
//   checksum   : running sum of the words written
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    num_words,
    ext_mem_loader_if.master    mem,
    output logic                proc_rst,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   checksum
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               err_q, err_d;
    logic               sum_clr, sum_en;
    logic [DATA_W-1:0]  sum_q;
    logic [31:0]        word_addr;
    logic               last_word;

    assign word_addr = BASE_ADDR + 32'(WORD_STRIDE) * 32'(cnt_q);
    assign last_word = (cnt_q == n_q - CNT_W'(1));

    ext_mem_loader_acc u_sum (
        .clk   (clk),
        .rst   (rst),
        .clr_i (sum_clr),
        .en_i  (sum_en),
        .d_i   (mem.in_data),
        .q_o   (sum_q)
    );

`ifdef EXT_MEM_LOADER_VERIFY_EN
    logic               rsum_clr, rsum_en;
    logic [DATA_W-1:0]  rsum_q;

    ext_mem_loader_acc u_rsum (
        .clk   (clk),
        .rst   (rst),
        .clr_i (rsum_clr),
        .en_i  (rsum_en),
        .d_i   (mem.ext_dmemresp_rdata),
        .q_o   (rsum_q)
    );
`endif

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            err_q   <= err_d;
        end
    end

    // Next state, request generation and accumulator control.
    always_comb begin
        state_d                = state_q;
        cnt_d                  = cnt_q;
        n_d                    = n_q;
        err_d                  = err_q;
        sum_clr                = 1'b0;
        sum_en                 = 1'b0;
`ifdef EXT_MEM_LOADER_VERIFY_EN
        rsum_clr               = 1'b0;
        rsum_en                = 1'b0;
`endif
        mem.in_rdy             = 1'b0;
        mem.ext_dmemreq_val    = 1'b0;
        mem.ext_dmemreq_type   = MEMREQ_READ;
        mem.ext_dmemreq_addr   = '0;
        mem.ext_dmemreq_wdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (32'(num_words) > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        n_d     = num_words;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        sum_clr = 1'b1;
`ifdef EXT_MEM_LOADER_VERIFY_EN
                        rsum_clr = 1'b1;
`endif
                        state_d = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                mem.in_rdy = 1'b1;
                if (mem.in_val) begin
                    mem.ext_dmemreq_val   = 1'b1;
                    mem.ext_dmemreq_type  = MEMREQ_WRITE;
                    mem.ext_dmemreq_addr  = word_addr;
                    mem.ext_dmemreq_wdata = mem.in_data;
                    sum_en                = 1'b1;
                    if (last_word) begin
                        cnt_d = '0;
`ifdef EXT_MEM_LOADER_VERIFY_EN
                        state_d = ST_VERIFY;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

`ifdef EXT_MEM_LOADER_VERIFY_EN
            ST_VERIFY: begin
                mem.ext_dmemreq_val  = 1'b1;
                mem.ext_dmemreq_type = MEMREQ_READ;
                mem.ext_dmemreq_addr = word_addr;
                rsum_en              = 1'b1;
                if (last_word) begin
                    // rsum_q lags by one read, so fold in the current word.
                    if (rsum_q + mem.ext_dmemresp_rdata != sum_q) err_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy     = (state_q == ST_WRITE) || (state_q == ST_VERIFY);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q;
    assign checksum = sum_q;
    assign proc_rst = rst | busy;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Directed bench for ext_mem_loader: a per-cycle vector table plus a few
// hand-written multi-cycle sequences, against a small word-memory model.
module tb_ext_mem_loader;

    localparam int unsigned CNT_W = 16;

    logic              clk;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  num_words;
    logic              proc_rst, busy, done, err;
    logic [31:0]       checksum;

    ext_mem_loader_if bus ();

    ext_mem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (1024),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .mem       (bus),
        .proc_rst  (proc_rst),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write committed at the edge.
    logic [31:0] mem_q [0:63];
    int          wr_cnt;
    assign bus.ext_dmemresp_rdata = mem_q[bus.ext_dmemreq_addr[7:2]];
    always @(posedge clk) begin
        if (bus.ext_dmemreq_val && bus.ext_dmemreq_type) begin
            mem_q[bus.ext_dmemreq_addr[7:2]] <= bus.ext_dmemreq_wdata;
            wr_cnt = wr_cnt + 1;
        end
    end

    int total;
    int bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        start;
        logic [15:0] nw;
        logic        iv;
        logic [31:0] id;
        logic        rdy;
        logic        val;
        logic        typ;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        busy;
        logic        done;
        logic        err;
        logic        prst;
        logic [31:0] cks;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic r, input logic s, input logic [15:0] nw,
                       input logic iv, input logic [31:0] id,
                       input logic rdy, input logic val, input logic typ,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic bsy, input logic dn, input logic er,
                       input logic prst, input logic [31:0] cks);
        row_t x;
        x.rst = r;   x.start = s;  x.nw = nw;   x.iv = iv;   x.id = id;
        x.rdy = rdy; x.val = val;  x.typ = typ; x.addr = addr; x.wd = wd;
        x.busy = bsy; x.done = dn; x.err = er;  x.prst = prst; x.cks = cks;
        tbl.push_back(x);
    endtask

    // One cycle of stimulus applied at the falling edge, outputs settle by +1.
    task automatic step(input logic s, input logic [15:0] nw,
                        input logic iv, input logic [31:0] id);
        @(negedge clk);
        start = s; num_words = nw; bus.in_val = iv; bus.in_data = id;
        #1;
    endtask

    // Builds the rows of one 4-word load starting from IDLE.
    task automatic add_load4(input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3,
                             input logic [31:0] prev_cks, input logic gap);
        logic [31:0] d [4];
        logic [31:0] acc;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        add(0, 1, 16'd4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, prev_cks);
        acc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (gap && i == 2) begin
                for (int g = 0; g < 3; g++)
                    add(0, 0, 0, 0, 32'hDEAD, 1, 0, 0, 0, 0, 1, 0, 0, 1, acc);
            end
            add(0, 0, 0, 1, d[i], 1, 1, 1, 32'(4 * i), d[i], 1, 0, 0, 1, acc);
            acc = acc + d[i];
        end
`ifdef EXT_MEM_LOADER_VERIFY_EN
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 0, 0, 0, 1, 0, 32'(4 * i), 0, 1, 0, 0, 1, acc);
`endif
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, acc);
    endtask

    initial begin
        total = 0; bad = 0; wr_cnt = 0;
        for (int i = 0; i < 64; i++) mem_q[i] = 32'h0;
        rst = 1'b1; start = 1'b0; num_words = '0;
        bus.in_val = 1'b0; bus.in_data = '0;

        // Reset state.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        // Back-to-back load, then idle.
        add_load4(32'h11, 32'h22, 32'h33, 32'h44, 32'h0, 1'b0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hAA);
        // Load with a 3-cycle stall after word 2.
        add_load4(32'h1, 32'h2, 32'h3, 32'h4, 32'hAA, 1'b1);
        // num_words = 0: straight to DONE, no error.
        add(0, 1, 16'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'hA);
        // num_words = MAX_WORDS+1: error, no writes, err sticky in IDLE.
        add(0, 1, 16'd1025, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hA);
        add(0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hA);
        add(0, 0, 0, 1, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hA);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst = tbl[k].rst; start = tbl[k].start; num_words = tbl[k].nw;
            bus.in_val = tbl[k].iv; bus.in_data = tbl[k].id;
            #1;
            chk($sformatf("row%0d.in_rdy", k),   bus.in_rdy,            tbl[k].rdy);
            chk($sformatf("row%0d.val", k),      bus.ext_dmemreq_val,   tbl[k].val);
            chk($sformatf("row%0d.type", k),     bus.ext_dmemreq_type,  tbl[k].typ);
            chk($sformatf("row%0d.addr", k),     bus.ext_dmemreq_addr,  tbl[k].addr);
            chk($sformatf("row%0d.wdata", k),    bus.ext_dmemreq_wdata, tbl[k].wd);
            chk($sformatf("row%0d.busy", k),     busy,                  tbl[k].busy);
            chk($sformatf("row%0d.done", k),     done,                  tbl[k].done);
            chk($sformatf("row%0d.err", k),      err,                   tbl[k].err);
            chk($sformatf("row%0d.proc_rst", k), proc_rst,              tbl[k].prst);
            chk($sformatf("row%0d.checksum", k), checksum,              tbl[k].cks);
        end

        // Memory dump after the second load, and total write count.
        for (int i = 0; i < 4; i++) chk($sformatf("mem[%0d]", i), mem_q[i], 32'(i + 1));
        chk("mem[4]_untouched", mem_q[4], 32'h0);
        chk("write_count", 32'(wr_cnt), 32'd8);

        // Reset after 2 of 5 words.
        step(1'b1, 16'd5, 1'b0, 32'h0);
        step(1'b0, 16'd0, 1'b1, 32'h100);
        chk("rst_seq.addr0", bus.ext_dmemreq_addr, 32'h0);
        step(1'b0, 16'd0, 1'b1, 32'h200);
        chk("rst_seq.addr1", bus.ext_dmemreq_addr, 32'h4);
        @(negedge clk);
        rst = 1'b1; bus.in_val = 1'b0;
        #1;
        chk("rst_seq.prst_in_rst", proc_rst, 32'd1);
        @(negedge clk);
        #1;
        chk("rst_seq.busy_after", busy, 32'd0);
        chk("rst_seq.in_rdy_after", bus.in_rdy, 32'd0);
        chk("rst_seq.prst_held", proc_rst, 32'd1);
        chk("rst_seq.cks_cleared", checksum, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_seq.prst_released", proc_rst, 32'd0);
        // Set err, then an accepted start must clear it.
        step(1'b1, 16'd2000, 1'b0, 32'h0);
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("rst_seq.err_set", err, 32'd1);
        step(1'b1, 16'd1, 1'b0, 32'h0);
        step(1'b0, 16'd0, 1'b1, 32'h7);
        chk("rst_seq.err_cleared", err, 32'd0);
        chk("rst_seq.new_addr", bus.ext_dmemreq_addr, 32'h0);
        chk("rst_seq.new_val", bus.ext_dmemreq_val, 32'd1);
`ifdef EXT_MEM_LOADER_VERIFY_EN
        step(1'b0, 16'd0, 1'b0, 32'h0);
`endif
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("rst_seq.done", done, 32'd1);
        chk("rst_seq.cks", checksum, 32'h7);

        // start pulsed during WRITE is ignored.
        step(1'b1, 16'd3, 1'b0, 32'h0);
        step(1'b0, 16'd0, 1'b1, 32'hA);
        chk("ign.addr0", bus.ext_dmemreq_addr, 32'h0);
        step(1'b1, 16'd1, 1'b0, 32'h0);
        chk("ign.no_req", bus.ext_dmemreq_val, 32'd0);
        chk("ign.busy", busy, 32'd1);
        step(1'b0, 16'd0, 1'b1, 32'hB);
        chk("ign.addr1", bus.ext_dmemreq_addr, 32'h4);
        chk("ign.busy1", busy, 32'd1);
        step(1'b0, 16'd0, 1'b1, 32'hC);
        chk("ign.addr2", bus.ext_dmemreq_addr, 32'h8);
        chk("ign.val2", bus.ext_dmemreq_val, 32'd1);
`ifdef EXT_MEM_LOADER_VERIFY_EN
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 1'b0, 32'h0);
`endif
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("ign.done", done, 32'd1);
        chk("ign.cks", checksum, 32'h21);

`ifdef EXT_MEM_LOADER_VERIFY_EN
        // Readback with a word altered behind the loader's back.
        step(1'b1, 16'd2, 1'b0, 32'h0);
        step(1'b0, 16'd0, 1'b1, 32'h5);
        step(1'b0, 16'd0, 1'b1, 32'h6);
        @(negedge clk);
        mem_q[0] = 32'h99; bus.in_val = 1'b0;
        #1;
        chk("vfy_bad.rd0_val", bus.ext_dmemreq_val, 32'd1);
        chk("vfy_bad.rd0_type", bus.ext_dmemreq_type, 32'd0);
        chk("vfy_bad.rd0_rdy", bus.in_rdy, 32'd0);
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("vfy_bad.rd1_addr", bus.ext_dmemreq_addr, 32'h4);
        chk("vfy_bad.rd1_type", bus.ext_dmemreq_type, 32'd0);
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("vfy_bad.done", done, 32'd1);
        chk("vfy_bad.err", err, 32'd1);
        // Unaltered readback.
        step(1'b1, 16'd2, 1'b0, 32'h0);
        step(1'b0, 16'd0, 1'b1, 32'h5);
        step(1'b0, 16'd0, 1'b1, 32'h6);
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("vfy_ok.rd0", bus.ext_dmemreq_val, 32'd1);
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("vfy_ok.rd1", bus.ext_dmemreq_val, 32'd1);
        step(1'b0, 16'd0, 1'b0, 32'h0);
        chk("vfy_ok.done", done, 32'd1);
        chk("vfy_ok.err", err, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
